// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared encodings for the memory bus master
package mem_bus_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2,
    SIZE_ILL  = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    STATUS_OK         = 2'd0,
    STATUS_MISALIGNED = 2'd1,
    STATUS_TIMEOUT    = 2'd2
  } status_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int unsigned TO_CNT_W = 16;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    case (size)
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = off[0];
      SIZE_WORD: mis = (off != 2'b00);
      default:   mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_bus_master_if.sv
// rtl/mem_bus_master_if.sv - command, response and memory bus signals
interface mem_bus_master_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [1:0]  cmd_size;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_status;

  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  // Seen from the bus master block itself.
  modport master (
    input  cmd_valid, cmd_write, cmd_size, cmd_addr, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_status,
    input  rsp_ready,
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  // Seen from the command source, response sink and memory.
  modport slave (
    output cmd_valid, cmd_write, cmd_size, cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_status,
    output rsp_ready,
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );

endinterface

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane strobes, write replication and read extraction
module mem_lane_align
  import mem_bus_pkg::*;
(
  input  logic        write,
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  always_comb begin
    wstrb     = 4'b1111;
    wdata_rep = wdata;
    rdata_ext = rdata;
    case (size)
      SIZE_BYTE: begin
        wstrb     = 4'b0001 << off;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {24'b0, rdata[{off, 3'b000} +: 8]};
      end
      SIZE_HALF: begin
        wstrb     = 4'b0011 << off;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {16'b0, rdata[{off[1], 4'b0000} +: 16]};
      end
      default: begin
        wstrb     = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = rdata;
      end
    endcase
    if (!write) begin
      wstrb = 4'b0000;
    end
  end

endmodule

// File: rtl/mem_bus_master.sv
// rtl/mem_bus_master.sv - single-outstanding command to memory bus master with timeout
module mem_bus_master
  import mem_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_bus_master_if.master  bus,
  output logic              busy
);

  localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT_CYCLES - 1);

  state_e              state;
  logic                lat_write;
  logic [1:0]          lat_size;
  logic [1:0]          lat_off;
  logic [TO_CNT_W-1:0] to_cnt;

  logic        al_write;
  logic [1:0]  al_size;
  logic [1:0]  al_off;
  logic [3:0]  al_wstrb;
  logic [31:0] al_wdata_rep;
  logic [31:0] al_rdata_ext;

  // In IDLE the aligner shapes the incoming command; afterwards it
  // extracts read lanes using the latched command.
  assign al_write = (state == IDLE) ? bus.cmd_write     : lat_write;
  assign al_size  = (state == IDLE) ? bus.cmd_size      : lat_size;
  assign al_off   = (state == IDLE) ? bus.cmd_addr[1:0] : lat_off;

  mem_lane_align u_align (
    .write     (al_write),
    .size      (al_size),
    .off       (al_off),
    .wdata     (bus.cmd_wdata),
    .rdata     (bus.mem_rdata),
    .wstrb     (al_wstrb),
    .wdata_rep (al_wdata_rep),
    .rdata_ext (al_rdata_ext)
  );

  assign bus.mem_instr = 1'b0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      lat_write      <= 1'b0;
      lat_size       <= SIZE_BYTE;
      lat_off        <= 2'b00;
      to_cnt         <= '0;
      bus.cmd_ready  <= 1'b1;
      bus.mem_valid  <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      bus.mem_wstrb  <= '0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_rdata  <= '0;
      bus.rsp_status <= STATUS_OK;
      busy           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid && bus.cmd_ready) begin
            lat_write     <= bus.cmd_write;
            lat_size      <= bus.cmd_size;
            lat_off       <= bus.cmd_addr[1:0];
            to_cnt        <= '0;
            bus.mem_addr  <= {bus.cmd_addr[31:2], 2'b00};
            bus.mem_wstrb <= al_wstrb;
            bus.mem_wdata <= al_wdata_rep;
            bus.cmd_ready <= 1'b0;
            busy          <= 1'b1;
            if (is_misaligned(bus.cmd_size, bus.cmd_addr[1:0])) begin
              state          <= RESP;
              bus.rsp_valid  <= 1'b1;
              bus.rsp_rdata  <= '0;
              bus.rsp_status <= STATUS_MISALIGNED;
            end else begin
              state         <= BUS;
              bus.mem_valid <= 1'b1;
            end
          end
        end
        BUS: begin
          // A ready in the final allowed cycle still counts as success.
          if (bus.mem_ready) begin
            state          <= RESP;
            bus.mem_valid  <= 1'b0;
            bus.rsp_valid  <= 1'b1;
            bus.rsp_rdata  <= lat_write ? 32'b0 : al_rdata_ext;
            bus.rsp_status <= STATUS_OK;
          end else if (to_cnt == TO_LAST) begin
            state          <= RESP;
            bus.mem_valid  <= 1'b0;
            bus.rsp_valid  <= 1'b1;
            bus.rsp_rdata  <= '0;
            bus.rsp_status <= STATUS_TIMEOUT;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_valid && bus.rsp_ready) begin
            state         <= IDLE;
            bus.rsp_valid <= 1'b0;
            bus.cmd_ready <= 1'b1;
            busy          <= 1'b0;
            to_cnt        <= '0;
          end
        end
        default: begin
          state         <= IDLE;
          bus.mem_valid <= 1'b0;
          bus.rsp_valid <= 1'b0;
          bus.cmd_ready <= 1'b1;
          busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_master.sv
// tb/tb_mem_bus_master.sv - self-checking bench with a lane-level behavioural model
module tb_mem_bus_master;
  import mem_bus_pkg::*;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  mem_bus_master_if bus ();

  mem_bus_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  bit          chk_en = 1'b0;
  bit          exp_bus;
  logic [31:0] exp_addr, exp_wdata, exp_rdata;
  logic [3:0]  exp_wstrb;
  logic [1:0]  exp_status;
  int          exp_nvalid;

  int          nvalid, rsp_cyc, rsp_hold;
  logic [31:0] cap_addr, cap_wdata, cap_rdata;
  logic [3:0]  cap_wstrb;
  logic [1:0]  cap_status;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // Per-cycle compare against the model's expectations for the current transaction.
  always @(negedge clk) begin
    if (chk_en) begin
      check("mem_instr", {31'b0, bus.mem_instr}, 32'd0);
      if (!exp_bus) check("no_mem_valid", {31'b0, bus.mem_valid}, 32'd0);
      if (bus.mem_valid) begin
        check("mem_addr", bus.mem_addr, exp_addr);
        check("mem_wstrb", {28'b0, bus.mem_wstrb}, {28'b0, exp_wstrb});
        check("mem_wdata", bus.mem_wdata, exp_wdata);
        check("busy_bus", {31'b0, busy}, 32'd1);
        check("cmd_ready_bus", {31'b0, bus.cmd_ready}, 32'd0);
      end
      if (bus.rsp_valid) begin
        check("rsp_rdata", bus.rsp_rdata, exp_rdata);
        check("rsp_status", {30'b0, bus.rsp_status}, {30'b0, exp_status});
        check("busy_resp", {31'b0, busy}, 32'd1);
        check("cmd_ready_resp", {31'b0, bus.cmd_ready}, 32'd0);
        check("mem_valid_resp", {31'b0, bus.mem_valid}, 32'd0);
      end
    end
  end

  task automatic run_txn(input logic w, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] rd, input int wt, input int rdly);
    int  nb, off;
    bit  mis, done;
    nb  = 1 << sz;
    off = int'(a % 4);
    mis = (sz == 2'd3) || ((off % nb) != 0);
    exp_bus   = !mis;
    exp_addr  = a - 32'(off);
    exp_wstrb = '0;
    exp_wdata = '0;
    exp_rdata = '0;
    if (!mis) begin
      for (int i = 0; i < 4; i++) begin
        if (w && i >= off && i < off + nb) exp_wstrb[i] = 1'b1;
        exp_wdata[8*i +: 8] = d[8*(i % nb) +: 8];
      end
      if (!w && wt < TO)
        for (int k = 0; k < nb; k++) exp_rdata[8*k +: 8] = rd[8*(off+k) +: 8];
    end
    exp_status = mis ? 2'd1 : (wt < TO ? 2'd0 : 2'd2);
    exp_nvalid = mis ? 0 : (wt < TO ? wt + 1 : TO);
    cap_addr = '0; cap_wdata = '0; cap_wstrb = '0; cap_rdata = '0; cap_status = '0;

    @(negedge clk);
    bus.mem_rdata = rd;
    bus.cmd_write = w;
    bus.cmd_size  = sz;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    bus.cmd_valid = 1'b1;
    bus.rsp_ready = 1'b0;
    check("cmd_ready_idle", {31'b0, bus.cmd_ready}, 32'd1);
    chk_en = 1'b1;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    nvalid = 0; rsp_cyc = 0; rsp_hold = 0; done = 1'b0;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(negedge clk);
      if (bus.mem_valid) begin
        nvalid++;
        cap_addr  = bus.mem_addr;
        cap_wstrb = bus.mem_wstrb;
        cap_wdata = bus.mem_wdata;
        bus.mem_ready = (nvalid == wt + 1);
      end else begin
        bus.mem_ready = 1'($urandom);
      end
      if (bus.rsp_valid) begin
        if (rsp_hold == 0) begin
          rsp_cyc    = c;
          cap_rdata  = bus.rsp_rdata;
          cap_status = bus.rsp_status;
        end
        rsp_hold++;
        bus.rsp_ready = (rsp_hold > rdly);
      end else if (rsp_hold > 0) begin
        done = 1'b1;
        bus.rsp_ready = 1'b0;
        check("cmd_ready_after_rsp", {31'b0, bus.cmd_ready}, 32'd1);
      end
    end
    chk_en = 1'b0;
    check("txn_completed", {31'b0, done}, 32'd1);
    check("mem_valid_cycles", nvalid, exp_nvalid);
    check("rsp_latency", rsp_cyc, mis ? 1 : exp_nvalid + 1);
    check("rsp_hold_cycles", rsp_hold, rdly + 1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_mem_valid"}, {31'b0, bus.mem_valid}, 32'd0);
    check({tag, "_mem_wstrb"}, {28'b0, bus.mem_wstrb}, 32'd0);
    check({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
    check({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
    check({tag, "_rsp_valid"}, {31'b0, bus.rsp_valid}, 32'd0);
    check({tag, "_rsp_rdata"}, bus.rsp_rdata, 32'd0);
    check({tag, "_rsp_status"}, {30'b0, bus.rsp_status}, 32'd0);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_cmd_ready"}, {31'b0, bus.cmd_ready}, 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_size = 2'd0;
    bus.cmd_addr = '0; bus.cmd_wdata = '0; bus.rsp_ready = 1'b0;
    bus.mem_ready = 1'b1; bus.mem_rdata = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_state("post_reset");

    // Word write, memory ready immediately.
    run_txn(1'b1, 2'd2, 32'h1000_0004, 32'h0000_0007, 32'h0, 0, 0);
    check("w_word_addr", cap_addr, 32'h1000_0004);
    check("w_word_wstrb", {28'b0, cap_wstrb}, 32'hF);
    check("w_word_nvalid", nvalid, 1);
    check("w_word_latency", rsp_cyc, 2);
    check("w_word_status", {30'b0, cap_status}, 32'd0);

    // Byte read from lane 3 after three wait cycles (ready on the last allowed cycle).
    run_txn(1'b0, 2'd0, 32'h0000_0003, 32'h0, 32'hAABB_CCDD, 3, 0);
    check("r_byte_wstrb", {28'b0, cap_wstrb}, 32'h0);
    check("r_byte_rdata", cap_rdata, 32'h0000_00AA);
    check("r_byte_status", {30'b0, cap_status}, 32'd0);
    check("r_byte_nvalid", nvalid, 4);

    // Half write to the upper half.
    run_txn(1'b1, 2'd1, 32'h0000_0002, 32'h0000_1234, 32'h0, 1, 0);
    check("w_half_wstrb", {28'b0, cap_wstrb}, 32'hC);
    check("w_half_wdata", cap_wdata, 32'h1234_1234);

    // Misaligned word and illegal size.
    run_txn(1'b0, 2'd2, 32'h0000_0006, 32'h0, 32'hFFFF_FFFF, 0, 0);
    check("mis_word_nvalid", nvalid, 0);
    check("mis_word_status", {30'b0, cap_status}, 32'd1);
    check("mis_word_rdata", cap_rdata, 32'd0);
    run_txn(1'b1, 2'd3, 32'h0000_0000, 32'h5555_5555, 32'h0, 0, 0);
    check("size3_status", {30'b0, cap_status}, 32'd1);

    // Timeout with ready held low.
    run_txn(1'b0, 2'd2, 32'h0000_0100, 32'h0, 32'h1234_5678, 100, 0);
    check("timeout_nvalid", nvalid, 4);
    check("timeout_status", {30'b0, cap_status}, 32'd2);
    check("timeout_rdata", cap_rdata, 32'd0);

    // Response back-pressure for five cycles.
    run_txn(1'b0, 2'd1, 32'h0000_0042, 32'h0, 32'hCAFE_BEEF, 0, 5);
    check("bp_rdata", cap_rdata, 32'h0000_CAFE);
    check("bp_hold", rsp_hold, 6);

    // Reset in the middle of a bus cycle abandons it.
    @(negedge clk);
    bus.mem_ready = 1'b0;
    bus.cmd_write = 1'b0; bus.cmd_size = 2'd2; bus.cmd_addr = 32'h0000_0020;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_valid_before", {31'b0, bus.mem_valid}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_state("rst_mid");
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      bus.mem_ready = 1'($urandom);
      check("rst_mid_no_rsp", {31'b0, bus.rsp_valid}, 32'd0);
      check("rst_mid_no_mem", {31'b0, bus.mem_valid}, 32'd0);
    end

    // Randomized transactions against the model.
    for (int n = 0; n < 60; n++) begin
      sz = ($urandom % 8 == 0) ? 2'd3 : 2'($urandom % 3);
      a  = $urandom;
      if (sz != 2'd3 && ($urandom % 4 != 0)) a = a & ~((32'd1 << sz) - 32'd1);
      run_txn(1'($urandom), sz, a, $urandom, $urandom,
              int'($urandom_range(0, 6)), int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
